// File: rtl/riscv_mem_arbiter.sv
// Fetch/data arbiter in front of one single-ported memory: registered issue,
// bounded fetch starvation, and a timeout that completes the access with an error.
//
// state | meaning
// IDLE  | no access in flight; sample requests and arbitrate
// ISSUE | mem_req held with the winner's payload; wait for mem_ack or timeout
// RESP  | one-cycle ack (with err/rdata) to the winner; requests not sampled
module riscv_mem_arbiter #(
   parameter int XLEN     = 32,
   parameter int MAX_WAIT = 4,
   parameter int TIMEOUT  = 16
) (
   input  logic            clk_i,
   input  logic            rst_ni,

   input  logic            if_req_i,
   input  logic [XLEN-1:0] if_addr_i,
   output logic            if_ack_o,
   output logic            if_err_o,
   output logic [XLEN-1:0] if_rdata_o,

   input  logic            d_req_i,
   input  logic            d_we_i,
   input  logic [XLEN-1:0] d_addr_i,
   input  logic [XLEN-1:0] d_wdata_i,
   output logic            d_ack_o,
   output logic            d_err_o,
   output logic [XLEN-1:0] d_rdata_o,

   output logic            mem_req_o,
   output logic            mem_we_o,
   output logic [XLEN-1:0] mem_addr_o,
   output logic [XLEN-1:0] mem_wdata_o,
   input  logic            mem_ack_i,
   input  logic [XLEN-1:0] mem_rdata_i
);

   localparam int SW = $clog2(MAX_WAIT + 1);
   localparam int TW = $clog2(TIMEOUT);
   localparam logic [SW-1:0] STARVE_MAX = SW'(MAX_WAIT);
   localparam logic [TW-1:0] TO_LAST    = TW'(TIMEOUT - 1);

   localparam logic [1:0] IDLE  = 2'd0;
   localparam logic [1:0] ISSUE = 2'd1;
   localparam logic [1:0] RESP  = 2'd2;

   logic [1:0]      state_q,     state_d;
   logic            owner_q,     owner_d;
   logic            err_q,       err_d;
   logic [XLEN-1:0] rdata_q,     rdata_d;
   logic [SW-1:0]   starve_q,    starve_d;
   logic [TW-1:0]   to_cnt_q,    to_cnt_d;
   logic            mem_req_q,   mem_req_d;
   logic            mem_we_q,    mem_we_d;
   logic [XLEN-1:0] mem_addr_q,  mem_addr_d;
   logic [XLEN-1:0] mem_wdata_q, mem_wdata_d;
   logic            grant_fetch;

   always_comb begin
      state_d     = state_q;
      owner_d     = owner_q;
      err_d       = err_q;
      rdata_d     = rdata_q;
      starve_d    = starve_q;
      to_cnt_d    = to_cnt_q;
      mem_req_d   = mem_req_q;
      mem_we_d    = mem_we_q;
      mem_addr_d  = mem_addr_q;
      mem_wdata_d = mem_wdata_q;
      grant_fetch = 1'b0;

      case (state_q)
         IDLE: begin
            if (if_req_i || d_req_i) begin
               // data is preferred until fetch has lost MAX_WAIT times in a row
               grant_fetch = if_req_i && (!d_req_i || (starve_q == STARVE_MAX));
               owner_d     = grant_fetch;
               mem_req_d   = 1'b1;
               to_cnt_d    = '0;
               state_d     = ISSUE;
               if (grant_fetch) begin
                  mem_we_d    = 1'b0;
                  mem_addr_d  = if_addr_i;
                  mem_wdata_d = '0;
                  starve_d    = '0;
               end else begin
                  mem_we_d    = d_we_i;
                  mem_addr_d  = d_addr_i;
                  mem_wdata_d = d_wdata_i;
                  if (if_req_i && (starve_q != STARVE_MAX)) begin
                     starve_d = starve_q + 1'b1;
                  end
               end
            end
         end
         ISSUE: begin
            to_cnt_d = to_cnt_q + 1'b1;
            if (mem_ack_i) begin
               rdata_d   = mem_we_q ? '0 : mem_rdata_i;
               err_d     = 1'b0;
               mem_req_d = 1'b0;
               state_d   = RESP;
            end else if (to_cnt_q == TO_LAST) begin
               rdata_d   = '0;
               err_d     = 1'b1;
               mem_req_d = 1'b0;
               state_d   = RESP;
            end
         end
         RESP: begin
            to_cnt_d = '0;
            state_d  = IDLE;
         end
         default: begin
            mem_req_d = 1'b0;
            to_cnt_d  = '0;
            state_d   = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q     <= IDLE;
         owner_q     <= 1'b0;
         err_q       <= 1'b0;
         rdata_q     <= '0;
         starve_q    <= '0;
         to_cnt_q    <= '0;
         mem_req_q   <= 1'b0;
         mem_we_q    <= 1'b0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
      end else begin
         state_q     <= state_d;
         owner_q     <= owner_d;
         err_q       <= err_d;
         rdata_q     <= rdata_d;
         starve_q    <= starve_d;
         to_cnt_q    <= to_cnt_d;
         mem_req_q   <= mem_req_d;
         mem_we_q    <= mem_we_d;
         mem_addr_q  <= mem_addr_d;
         mem_wdata_q <= mem_wdata_d;
      end
   end

   assign mem_req_o   = mem_req_q;
   assign mem_we_o    = mem_we_q;
   assign mem_addr_o  = mem_addr_q;
   assign mem_wdata_o = mem_wdata_q;

   assign if_ack_o   = (state_q == RESP) &&  owner_q;
   assign d_ack_o    = (state_q == RESP) && !owner_q;
   assign if_err_o   = if_ack_o && err_q;
   assign d_err_o    = d_ack_o  && err_q;
   assign if_rdata_o = if_ack_o ? rdata_q : '0;
   assign d_rdata_o  = d_ack_o  ? rdata_q : '0;

endmodule
